// File: rtl/warp_pc_scheduler.sv
// warp_pc_scheduler
//   Holds the eight per-warp fetch PCs and issues two one-hot fetch grants
//   per cycle. Arbitration is round-robin over warps that are active, hold
//   at least one I-buffer credit and are not being redirected this cycle.
//   Redirects (SIMT / decode replay) use the same masks fetch uses to kill
//   in-flight slots, so a redirected warp is never granted in that cycle.
//   Optional feature macro: WARP_SCHED_PERF_EN adds idle / dual-issue
//   saturating performance counters.
module warp_pc_scheduler #(
  parameter int unsigned IBUF_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        Launch_valid,
  input  logic [2:0]  Launch_warp,
  input  logic [31:0] Launch_PC,
  input  logic [7:0]  Exit_mask,
  input  logic [7:0]  UpdatePC_Qual1_SIMT_IF,
  input  logic [7:0]  UpdatePC_Qual2_SIMT_IF,
  input  logic [7:0]  UpdatePC_Qual3_ID0_IF,
  input  logic [7:0]  UpdatePC_Qual3_ID1_IF,
  input  logic [31:0] Target1_SIMT,
  input  logic [31:0] Target2_SIMT,
  input  logic [31:0] PC_ID0,
  input  logic [31:0] PC_ID1,
  input  logic [7:0]  IBuf_Deq_mask,
  output logic [31:0] PC0_PC_IF,
  output logic [31:0] PC1_PC_IF,
  output logic [31:0] PC2_PC_IF,
  output logic [31:0] PC3_PC_IF,
  output logic [31:0] PC4_PC_IF,
  output logic [31:0] PC5_PC_IF,
  output logic [31:0] PC6_PC_IF,
  output logic [31:0] PC7_PC_IF,
  output logic [7:0]  GRT_raw_1_RR_IF,
  output logic [7:0]  GRT_raw_2_RR_IF,
  output logic [7:0]  Active_mask
`ifdef WARP_SCHED_PERF_EN
  ,
  output logic [31:0] Perf_idle_cycles,
  output logic [31:0] Perf_dual_cycles
`endif
);

  localparam logic [3:0] CREDIT_MAX = 4'(IBUF_DEPTH);

  logic [31:0] pc_q     [8];
  logic [31:0] pc_d     [8];
  logic [3:0]  credit_q [8];
  logic [3:0]  credit_d [8];
  logic [7:0]  active_q;
  logic [7:0]  active_d;
  logic [2:0]  rr_ptr_q;
  logic [2:0]  rr_ptr_d;

  logic [7:0]  redir_s;
  logic [7:0]  eligible_s;
  logic [7:0]  grt0_s;
  logic [7:0]  grt1_s;
  logic [7:0]  granted_s;
  logic        found0_s;
  logic        found1_s;
  logic [2:0]  id0_s;
  logic [2:0]  id1_s;
  logic [2:0]  scan_idx_s;
  logic        launch_hit_s;
  logic [4:0]  credit_sum_s;

  // Eligibility and two-slot round-robin scan starting at rr_ptr.
  always_comb begin
    redir_s    = UpdatePC_Qual1_SIMT_IF | UpdatePC_Qual2_SIMT_IF |
                 UpdatePC_Qual3_ID0_IF  | UpdatePC_Qual3_ID1_IF;
    eligible_s = 8'h00;
    found0_s   = 1'b0;
    found1_s   = 1'b0;
    id0_s      = 3'd0;
    id1_s      = 3'd0;
    scan_idx_s = 3'd0;
    for (int w = 0; w < 8; w++) begin
      eligible_s[w] = active_q[w] & (credit_q[w] != 4'd0) & ~redir_s[w];
    end
    for (int k = 0; k < 8; k++) begin
      scan_idx_s = rr_ptr_q + 3'(k);
      if (eligible_s[scan_idx_s] && !found0_s) begin
        found0_s = 1'b1;
        id0_s    = scan_idx_s;
      end else if (eligible_s[scan_idx_s] && !found1_s) begin
        found1_s = 1'b1;
        id1_s    = scan_idx_s;
      end else begin
        // warp not eligible, or both slots already filled
        found1_s = found1_s;
      end
    end
    if (found0_s) begin
      grt0_s = 8'h01 << id0_s;
    end else begin
      grt0_s = 8'h00;
    end
    if (found1_s) begin
      grt1_s = 8'h01 << id1_s;
    end else begin
      grt1_s = 8'h00;
    end
    granted_s = grt0_s | grt1_s;
    // pointer moves just past the last warp granted this cycle
    if (found1_s) begin
      rr_ptr_d = id1_s + 3'd1;
    end else if (found0_s) begin
      rr_ptr_d = id0_s + 3'd1;
    end else begin
      rr_ptr_d = rr_ptr_q;
    end
  end

  // Per-warp next PC / active / credit with launch > exit > redirect > grant priority.
  always_comb begin
    active_d     = active_q;
    launch_hit_s = 1'b0;
    credit_sum_s = 5'd0;
    for (int w = 0; w < 8; w++) begin
      pc_d[w]     = pc_q[w];
      credit_d[w] = credit_q[w];
    end
    for (int w = 0; w < 8; w++) begin
      launch_hit_s = Launch_valid && (Launch_warp == 3'(w));
      // granted implies credit != 0, so this cannot underflow
      credit_sum_s = {1'b0, credit_q[w]} - {4'd0, granted_s[w]} + {4'd0, IBuf_Deq_mask[w]};
      if (launch_hit_s) begin
        pc_d[w]     = Launch_PC;
        active_d[w] = 1'b1;
        credit_d[w] = CREDIT_MAX;
      end else if (Exit_mask[w]) begin
        // exit freezes PC and credit, even over a same-cycle grant
        active_d[w] = 1'b0;
      end else if (redir_s[w]) begin
        if (UpdatePC_Qual1_SIMT_IF[w]) begin
          pc_d[w] = Target1_SIMT;
        end else if (UpdatePC_Qual2_SIMT_IF[w]) begin
          pc_d[w] = Target2_SIMT;
        end else if (UpdatePC_Qual3_ID0_IF[w]) begin
          pc_d[w] = PC_ID0;
        end else begin
          pc_d[w] = PC_ID1;
        end
        // the I-buffer of a live warp is flushed; an idle warp only moves its PC
        if (active_q[w]) begin
          credit_d[w] = CREDIT_MAX;
        end else begin
          credit_d[w] = credit_q[w];
        end
      end else begin
        if (granted_s[w]) begin
          pc_d[w] = pc_q[w] + 32'd4;
        end else begin
          pc_d[w] = pc_q[w];
        end
        if (credit_sum_s > {1'b0, CREDIT_MAX}) begin
          credit_d[w] = CREDIT_MAX;
        end else begin
          credit_d[w] = credit_sum_s[3:0];
        end
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      active_q <= 8'h00;
      rr_ptr_q <= 3'd0;
      for (int w = 0; w < 8; w++) begin
        pc_q[w]     <= 32'd0;
        credit_q[w] <= CREDIT_MAX;
      end
    end else begin
      active_q <= active_d;
      rr_ptr_q <= rr_ptr_d;
      for (int w = 0; w < 8; w++) begin
        pc_q[w]     <= pc_d[w];
        credit_q[w] <= credit_d[w];
      end
    end
  end

  assign PC0_PC_IF       = pc_q[0];
  assign PC1_PC_IF       = pc_q[1];
  assign PC2_PC_IF       = pc_q[2];
  assign PC3_PC_IF       = pc_q[3];
  assign PC4_PC_IF       = pc_q[4];
  assign PC5_PC_IF       = pc_q[5];
  assign PC6_PC_IF       = pc_q[6];
  assign PC7_PC_IF       = pc_q[7];
  assign GRT_raw_1_RR_IF = grt0_s;
  assign GRT_raw_2_RR_IF = grt1_s;
  assign Active_mask     = active_q;

`ifdef WARP_SCHED_PERF_EN
  logic [31:0] perf_idle_q;
  logic [31:0] perf_idle_d;
  logic [31:0] perf_dual_q;
  logic [31:0] perf_dual_d;

  // Saturating idle / dual-issue cycle counters.
  always_comb begin
    perf_idle_d = perf_idle_q;
    perf_dual_d = perf_dual_q;
    if ((active_q != 8'h00) && (grt0_s == 8'h00) && (grt1_s == 8'h00) &&
        (perf_idle_q != 32'hFFFF_FFFF)) begin
      perf_idle_d = perf_idle_q + 32'd1;
    end else begin
      perf_idle_d = perf_idle_q;
    end
    if ((grt0_s != 8'h00) && (grt1_s != 8'h00) && (perf_dual_q != 32'hFFFF_FFFF)) begin
      perf_dual_d = perf_dual_q + 32'd1;
    end else begin
      perf_dual_d = perf_dual_q;
    end
  end

  // Counter registers, cleared by reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_idle_q <= 32'd0;
      perf_dual_q <= 32'd0;
    end else begin
      perf_idle_q <= perf_idle_d;
      perf_dual_q <= perf_dual_d;
    end
  end

  assign Perf_idle_cycles = perf_idle_q;
  assign Perf_dual_cycles = perf_dual_q;
`endif

endmodule
